// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus master: access sizes, idle bus address,
// FSM state encodings and grant identifiers.
package bus_pkg;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // An address that the system decoder maps to no device; driven whenever the bus is idle.
  localparam logic [31:0] BUS_IDLE_ADDR = 32'hFFFF_FFFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  // Word accesses must be 4-byte aligned; byte accesses never fault.
  function automatic logic is_misaligned(input logic size, input logic [1:0] lo);
    return (size == SIZE_WORD) && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Request/response handshakes of the fetch and data ports plus the system bus master port.
interface bus_master_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;

  logic        mem_req;
  logic        mem_write;
  logic        mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;

  logic        Hsize;
  logic        Hwrite;
  logic [31:0] Hwritedata;
  logic [31:0] Haddress;
  logic [31:0] Hreaddata;
  logic        Hresponse;
  logic        Hready;

  // The arbiter is the bus master; the CPU pipeline and bus decoder form the other side.
  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_write, mem_size, mem_sign, mem_addr, mem_wdata,
    input  Hreaddata, Hresponse, Hready,
    output if_rdata, if_done, if_err,
    output mem_rdata, mem_done, mem_err,
    output Hsize, Hwrite, Hwritedata, Haddress
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_write, mem_size, mem_sign, mem_addr, mem_wdata,
    output Hreaddata, Hresponse, Hready,
    input  if_rdata, if_done, if_err,
    input  mem_rdata, mem_done, mem_err,
    input  Hsize, Hwrite, Hwritedata, Haddress
  );

endinterface

// File: rtl/bus_read_align.sv
// Read-data formatter: picks the addressed byte lane for byte loads and extends it.
module bus_read_align
  import bus_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0] byte_sel;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    data = rdata;
    if (size == SIZE_BYTE) data = {{24{sign & byte_sel[7]}}, byte_sel};
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Arbitrates fetch and data requests onto the single system bus master port, one
// transaction at a time, with alignment checking, byte-lane handling and a wait timeout.
module bus_master_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          MEM_PRIORITY   = 1'b1
) (
  input logic                   Hclock,
  input logic                   Hreset,
  bus_master_arbiter_if.master  bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  gnt_e       gnt;
  logic       rr_mem;      // 1: mem wins the next contended grant
  logic [7:0] wait_cnt;
  logic       cur_write;
  logic       cur_size;
  logic       cur_sign;
  logic [1:0] cur_lane;

  // A requester still seeing its done pulse is holding a stale request.
  logic if_elig, mem_elig, any_elig;
  assign if_elig  = bus.if_req  & ~bus.if_done;
  assign mem_elig = bus.mem_req & ~bus.mem_done;
  assign any_elig = if_elig | mem_elig;

  gnt_e        pick;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_size;
  logic        req_write;
  logic        req_sign;

  always_comb begin
    pick = GNT_IF;
    if (mem_elig && (!if_elig || MEM_PRIORITY || rr_mem)) pick = GNT_MEM;

    req_addr  = bus.if_addr;
    req_size  = SIZE_WORD;
    req_write = 1'b0;
    req_sign  = 1'b0;
    req_wdata = '0;
    if (pick == GNT_MEM) begin
      req_addr  = bus.mem_addr;
      req_size  = bus.mem_size;
      req_write = bus.mem_write;
      req_sign  = bus.mem_sign;
      if (bus.mem_write)
        req_wdata = (bus.mem_size == SIZE_BYTE) ? {4{bus.mem_wdata[7:0]}} : bus.mem_wdata;
    end
  end

  logic [31:0] aligned;

  bus_read_align u_align (
    .rdata (bus.Hreaddata),
    .lane  (cur_lane),
    .size  (cur_size),
    .sign  (cur_sign),
    .data  (aligned)
  );

  // Completion of the current (or rejected) transaction at this edge.
  logic        fin;
  gnt_e        fin_gnt;
  logic        fin_err;
  logic [31:0] fin_data;

  always_comb begin
    fin      = 1'b0;
    fin_gnt  = gnt;
    fin_err  = 1'b0;
    fin_data = '0;
    if (state == ST_IDLE) begin
      if (any_elig && is_misaligned(req_size, req_addr[1:0])) begin
        fin     = 1'b1;
        fin_gnt = pick;
        fin_err = 1'b1;
      end
    end else if (bus.Hready) begin
      fin      = 1'b1;
      fin_err  = bus.Hresponse;
      fin_data = cur_write ? '0 : aligned;
    end else if (wait_cnt == TIMEOUT_LAST) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      state          <= ST_IDLE;
      gnt            <= GNT_MEM;
      rr_mem         <= 1'b1;
      wait_cnt       <= '0;
      cur_write      <= 1'b0;
      cur_size       <= SIZE_WORD;
      cur_sign       <= 1'b0;
      cur_lane       <= 2'b00;
      bus.Haddress   <= BUS_IDLE_ADDR;
      bus.Hwrite     <= 1'b0;
      bus.Hsize      <= SIZE_WORD;
      bus.Hwritedata <= '0;
      bus.if_done    <= 1'b0;
      bus.if_err     <= 1'b0;
      bus.if_rdata   <= '0;
      bus.mem_done   <= 1'b0;
      bus.mem_err    <= 1'b0;
      bus.mem_rdata  <= '0;
    end else begin
      bus.if_done  <= fin && (fin_gnt == GNT_IF);
      bus.if_err   <= fin && (fin_gnt == GNT_IF) && fin_err;
      bus.mem_done <= fin && (fin_gnt == GNT_MEM);
      bus.mem_err  <= fin && (fin_gnt == GNT_MEM) && fin_err;
      if (fin && (fin_gnt == GNT_IF))  bus.if_rdata  <= fin_data;
      if (fin && (fin_gnt == GNT_MEM)) bus.mem_rdata <= fin_data;

      if (state == ST_IDLE) begin
        if (if_elig && mem_elig) rr_mem <= (pick == GNT_IF);
        if (any_elig && !fin) begin
          state          <= ST_BUSY;
          gnt            <= pick;
          wait_cnt       <= '0;
          cur_write      <= req_write;
          cur_size       <= req_size;
          cur_sign       <= req_sign;
          cur_lane       <= req_addr[1:0];
          bus.Haddress   <= req_addr;
          bus.Hwrite     <= req_write;
          bus.Hsize      <= req_size;
          bus.Hwritedata <= req_wdata;
        end
      end else if (fin) begin
        state          <= ST_IDLE;
        bus.Haddress   <= BUS_IDLE_ADDR;
        bus.Hwrite     <= 1'b0;
        bus.Hsize      <= SIZE_WORD;
        bus.Hwritedata <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: directed scenarios plus randomized single
// transactions compared against a behavioural model of the access rules.
module tb_bus_master_arbiter;

  logic Hclock = 1'b0;
  logic Hreset = 1'b1;
  always #5 Hclock = ~Hclock;

  bus_master_arbiter_if bif ();
  bus_master_arbiter_if rif ();

  bus_master_arbiter #(.TIMEOUT_CYCLES(255), .MEM_PRIORITY(1'b1)) dut (
    .Hclock (Hclock),
    .Hreset (Hreset),
    .bus    (bif)
  );

  bus_master_arbiter #(.TIMEOUT_CYCLES(16), .MEM_PRIORITY(1'b0)) dut_rr (
    .Hclock (Hclock),
    .Hreset (Hreset),
    .bus    (rif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(posedge Hclock);
    @(negedge Hclock);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] w, input logic [1:0] off,
                                              input bit byte_acc, input bit sgn);
    logic [31:0] v;
    if (!byte_acc) return w;
    v = (w >> (32'(off) * 8)) & 32'h0000_00FF;
    if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  // One complete transaction on the priority instance, expectations from the access rules.
  task automatic run_txn(input string tag, input bit is_mem, input logic [31:0] addr,
                         input bit wr, input bit sz, input bit sg, input logic [31:0] wd,
                         input int delay, input bit resp, input logic [31:0] hrd,
                         input bit rdy_at_grant, input bit drop_early);
    bit eff_wr, eff_sz, mis;
    logic [31:0] exp_wd, exp_rd;
    eff_wr = is_mem && wr;
    eff_sz = is_mem && sz;
    mis    = !eff_sz && (addr[1:0] != 2'b00);
    exp_wd = !eff_wr ? 32'h0 : (eff_sz ? {4{wd[7:0]}} : wd);
    exp_rd = eff_wr ? 32'h0 : model_read(hrd, addr[1:0], eff_sz, is_mem && sg);

    if (is_mem) begin
      bif.mem_req = 1'b1; bif.mem_addr = addr; bif.mem_write = wr;
      bif.mem_size = sz;  bif.mem_sign = sg;   bif.mem_wdata = wd;
    end else begin
      bif.if_req = 1'b1; bif.if_addr = addr;
    end
    bif.Hready = rdy_at_grant; bif.Hresponse = 1'b0; bif.Hreaddata = ~hrd;
    step();

    if (mis) begin
      check({tag, ":mis_done"}, is_mem ? bif.mem_done : bif.if_done, 1);
      check({tag, ":mis_err"}, is_mem ? bif.mem_err : bif.if_err, 1);
      check({tag, ":mis_rdata"}, is_mem ? bif.mem_rdata : bif.if_rdata, 0);
      check({tag, ":mis_addr"}, bif.Haddress, 32'hFFFF_FFFF);
      bif.if_req = 1'b0; bif.mem_req = 1'b0; bif.Hready = 1'b0;
      step();
      check({tag, ":mis_pulse"}, {bif.if_done, bif.mem_done}, 0);
      return;
    end

    check({tag, ":addr"}, bif.Haddress, addr);
    check({tag, ":write"}, bif.Hwrite, eff_wr);
    check({tag, ":size"}, bif.Hsize, eff_sz);
    check({tag, ":wdata"}, bif.Hwritedata, exp_wd);
    check({tag, ":early_done"}, {bif.if_done, bif.mem_done}, 0);
    if (drop_early) begin bif.if_req = 1'b0; bif.mem_req = 1'b0; end
    bif.Hready = 1'b0;
    for (int k = 0; k < delay; k++) begin
      step();
      check({tag, ":hold_addr"}, bif.Haddress, addr);
      check({tag, ":hold_wdata"}, bif.Hwritedata, exp_wd);
      check({tag, ":wait_done"}, {bif.if_done, bif.mem_done}, 0);
    end
    bif.Hready = 1'b1; bif.Hresponse = resp; bif.Hreaddata = hrd;
    step();
    check({tag, ":done"}, is_mem ? bif.mem_done : bif.if_done, 1);
    check({tag, ":other_done"}, is_mem ? bif.if_done : bif.mem_done, 0);
    check({tag, ":err"}, is_mem ? bif.mem_err : bif.if_err, resp);
    if (!resp) check({tag, ":rdata"}, is_mem ? bif.mem_rdata : bif.if_rdata, exp_rd);
    check({tag, ":idle_addr"}, bif.Haddress, 32'hFFFF_FFFF);
    check({tag, ":idle_write"}, bif.Hwrite, 0);
    bif.if_req = 1'b0; bif.mem_req = 1'b0; bif.Hready = 1'b0; bif.Hresponse = 1'b0;
    step();
    check({tag, ":pulse"}, {bif.if_done, bif.mem_done}, 0);
  endtask

  initial begin
    logic [31:0] addr;
    int n;
    bit rr_ptr_mem;
    bit win_mem;

    bif.if_req = 0; bif.if_addr = 0; bif.mem_req = 0; bif.mem_write = 0; bif.mem_size = 0;
    bif.mem_sign = 0; bif.mem_addr = 0; bif.mem_wdata = 0;
    bif.Hreaddata = 0; bif.Hresponse = 0; bif.Hready = 0;
    rif.if_req = 0; rif.if_addr = 0; rif.mem_req = 0; rif.mem_write = 0; rif.mem_size = 0;
    rif.mem_sign = 0; rif.mem_addr = 0; rif.mem_wdata = 0;
    rif.Hreaddata = 0; rif.Hresponse = 0; rif.Hready = 0;

    Hreset = 1'b1;
    step(); step();
    check("rst:addr", bif.Haddress, 32'hFFFF_FFFF);
    check("rst:write_size", {bif.Hwrite, bif.Hsize}, 0);
    check("rst:wdata", bif.Hwritedata, 0);
    check("rst:done_err", {bif.if_done, bif.if_err, bif.mem_done, bif.mem_err}, 0);
    check("rst:if_rdata", bif.if_rdata, 0);
    check("rst:mem_rdata", bif.mem_rdata, 0);
    Hreset = 1'b0;

    // Minimum-latency fetch; Hready already high at the grant edge must be ignored.
    bif.if_req = 1'b1; bif.if_addr = 32'h1FC0_0000; bif.Hready = 1'b1; bif.Hreaddata = 32'h0;
    step();
    check("fetch:cycle1_done", bif.if_done, 0);
    check("fetch:addr", bif.Haddress, 32'h1FC0_0000);
    bif.Hreaddata = 32'h3C08_BFD0;
    step();
    check("fetch:cycle2_done", bif.if_done, 1);
    check("fetch:rdata", bif.if_rdata, 32'h3C08_BFD0);
    check("fetch:err", bif.if_err, 0);
    bif.if_req = 1'b0; bif.Hready = 1'b0;
    step();
    check("fetch:pulse", bif.if_done, 0);

    run_txn("lb_sign",   1, 32'h0000_0003, 0, 1, 1, 0, 0, 0, 32'h80FF_0000, 0, 0);
    run_txn("lbu",       1, 32'h0000_0003, 0, 1, 0, 0, 1, 0, 32'h80FF_0000, 0, 0);
    run_txn("sb",        1, 32'h1FD0_03F8, 1, 1, 0, 32'h1234_5641, 3, 0, 32'h0, 0, 0);
    run_txn("lw_mis",    1, 32'h0000_0002, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    run_txn("fetch_mis", 0, 32'h1FC0_0001, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    run_txn("lw_berr",   1, 32'h2000_0000, 0, 0, 0, 0, 2, 1, 32'h0, 0, 0);
    run_txn("sw_drop",   1, 32'h0000_0100, 1, 0, 0, 32'hCAFE_F00D, 2, 0, 32'h0, 1, 1);

    // Simultaneous requests with mem priority: mem first, then fetch.
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_1000;
    bif.mem_req = 1'b1; bif.mem_addr = 32'h0000_2000; bif.mem_write = 0; bif.mem_size = 0;
    bif.Hready = 1'b1; bif.Hreaddata = 32'h5555_AAAA;
    step();
    check("prio:first_addr", bif.Haddress, 32'h0000_2000);
    step();
    check("prio:mem_done", {bif.mem_done, bif.if_done}, 2'b10);
    bif.mem_req = 1'b0;
    step();
    check("prio:second_addr", bif.Haddress, 32'h0000_1000);
    step();
    check("prio:if_done", {bif.mem_done, bif.if_done}, 2'b01);
    bif.if_req = 1'b0; bif.Hready = 1'b0;
    step();

    // Round-robin instance: two contended pairs, winner = last loser (initially mem).
    rr_ptr_mem = 1'b1;
    rif.if_addr = 32'h0000_0400; rif.mem_addr = 32'h0000_0800;
    rif.mem_write = 0; rif.mem_size = 0; rif.Hreaddata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      win_mem = rr_ptr_mem;
      rr_ptr_mem = !win_mem;
      rif.if_req = 1'b1; rif.mem_req = 1'b1; rif.Hready = 1'b1;
      step();
      check("rr:winner_addr", rif.Haddress, win_mem ? 32'h0000_0800 : 32'h0000_0400);
      step();
      check("rr:winner_done", {rif.mem_done, rif.if_done}, win_mem ? 2'b10 : 2'b01);
      if (win_mem) rif.mem_req = 1'b0; else rif.if_req = 1'b0;
      step();
      check("rr:loser_addr", rif.Haddress, win_mem ? 32'h0000_0400 : 32'h0000_0800);
      step();
      check("rr:loser_done", {rif.mem_done, rif.if_done}, win_mem ? 2'b01 : 2'b10);
      rif.if_req = 1'b0; rif.mem_req = 1'b0; rif.Hready = 1'b0;
      step();
      check("rr:quiet", {rif.mem_done, rif.if_done}, 0);
    end

    // Timeout on the short-timeout instance.
    rif.mem_req = 1'b1; rif.mem_addr = 32'h0000_0040; rif.Hready = 1'b0;
    step();
    n = 0;
    while (n < 40 && !rif.mem_done) begin step(); n++; end
    check("rr_to:cycles", n, 16);
    check("rr_to:err", rif.mem_err, 1);
    check("rr_to:rdata", rif.mem_rdata, 0);
    check("rr_to:addr", rif.Haddress, 32'hFFFF_FFFF);
    rif.mem_req = 1'b0;
    step();

    // Timeout on the default instance.
    bif.mem_req = 1'b1; bif.mem_addr = 32'h0000_0104; bif.mem_write = 0; bif.mem_size = 0;
    bif.Hready = 1'b0;
    step();
    n = 0;
    while (n < 300 && !bif.mem_done) begin step(); n++; end
    check("to:cycles", n, 255);
    check("to:err", bif.mem_err, 1);
    check("to:rdata", bif.mem_rdata, 0);
    bif.mem_req = 1'b0;
    step();
    check("to:pulse", bif.mem_done, 0);

    // Reset in the middle of a bus cycle.
    bif.mem_req = 1'b1; bif.mem_addr = 32'h0000_0200; bif.mem_write = 1; bif.mem_size = 1;
    bif.mem_wdata = 32'h0000_00A5; bif.Hready = 1'b0;
    step();
    check("rst_busy:addr", bif.Haddress, 32'h0000_0200);
    step(); step();
    Hreset = 1'b1;
    step();
    check("rst_busy:idle_addr", bif.Haddress, 32'hFFFF_FFFF);
    check("rst_busy:ctl", {bif.Hwrite, bif.Hsize}, 0);
    check("rst_busy:wdata", bif.Hwritedata, 0);
    check("rst_busy:done", {bif.mem_done, bif.mem_err}, 0);
    bif.mem_req = 1'b0; Hreset = 1'b0;
    step(); step();
    check("rst_busy:no_done", {bif.mem_done, bif.if_done}, 0);
    check("rst_busy:still_idle", bif.Haddress, 32'hFFFF_FFFF);

    // Randomized single transactions.
    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_txn("rand", 1'($urandom_range(0, 1)), addr, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
